// File: rtl/ex_stage_if.sv
// ID/EX-to-EX/MEM bundle for the RV32I execute stage.
// The E-side inputs, the hazard controls, the redirect and the registered M-side outputs.
interface ex_stage_if;
    logic        StallM;
    logic        FlushM;
    logic [31:0] RD1E;
    logic [31:0] RD2E;
    logic [31:0] PCE;
    logic [31:0] ImmExtE;
    logic [3:0]  ALUOpE;
    logic [1:0]  ALUSrcAE;
    logic [1:0]  ALUSrcBE;
    logic [2:0]  funct3E;
    logic        BranchE;
    logic        JumpE;
    logic        MuxjalrE;
    logic        RegWriteE;
    logic        MemReadE;
    logic        MemWriteE;
    logic [2:0]  WriteBackE;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [31:0] ResultW;

    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] PCPlus4M;
    logic [31:0] ImmExtM;
    logic [4:0]  RdM;
    logic [2:0]  funct3M;
    logic [2:0]  WriteBackM;
    logic        RegWriteM;
    logic        MemReadM;
    logic        MemWriteM;

    modport slave (
        input  StallM, FlushM, RD1E, RD2E, PCE, ImmExtE, ALUOpE, ALUSrcAE, ALUSrcBE,
               funct3E, BranchE, JumpE, MuxjalrE, RegWriteE, MemReadE, MemWriteE,
               WriteBackE, RdE, ForwardAE, ForwardBE, ResultW,
        output PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M, ImmExtM, RdM,
               funct3M, WriteBackM, RegWriteM, MemReadM, MemWriteM
    );

    modport master (
        output StallM, FlushM, RD1E, RD2E, PCE, ImmExtE, ALUOpE, ALUSrcAE, ALUSrcBE,
               funct3E, BranchE, JumpE, MuxjalrE, RegWriteE, MemReadE, MemWriteE,
               WriteBackE, RdE, ForwardAE, ForwardBE, ResultW,
        input  PCSrcE, PCTargetE, ALUResultM, WriteDataM, PCPlus4M, ImmExtM, RdM,
               funct3M, WriteBackM, RegWriteM, MemReadM, MemWriteM
    );
endinterface

// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, ALU, branch compare, jump target and the EX/MEM register.
// The redirect (PCSrcE/PCTargetE) is combinational; everything M-side is registered.
module ex_stage #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        reset,
    ex_stage_if.slave   bus
);

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] imm_ext;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [2:0]      write_back;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } m_regs_t;

    logic [XLEN-1:0] fwd_a, fwd_b, src_a, src_b, alu_result, pc_plus4;
    logic [4:0]      shamt;
    logic            taken;
    m_regs_t         m_q, m_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        fwd_a = bus.RD1E;
        case (bus.ForwardAE)
            2'b01:   fwd_a = bus.ResultW;
            2'b10:   fwd_a = m_q.alu_result;
            default: fwd_a = bus.RD1E;
        endcase

        fwd_b = bus.RD2E;
        case (bus.ForwardBE)
            2'b01:   fwd_b = bus.ResultW;
            2'b10:   fwd_b = m_q.alu_result;
            default: fwd_b = bus.RD2E;
        endcase

        src_a = '0;
        case (bus.ALUSrcAE)
            2'd0:    src_a = fwd_a;
            2'd1:    src_a = bus.PCE;
            default: src_a = '0;
        endcase

        src_b = XLEN'(4);
        case (bus.ALUSrcBE)
            2'd0:    src_b = fwd_b;
            2'd1:    src_b = bus.ImmExtE;
            default: src_b = XLEN'(4);
        endcase
    end

    assign shamt = src_b[4:0];

    always_comb begin
        alu_result = '0;
        case (bus.ALUOpE)
            4'd0:    alu_result = src_a + src_b;
            4'd1:    alu_result = src_a - src_b;
            4'd2:    alu_result = src_a << shamt;
            4'd3:    alu_result = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            4'd4:    alu_result = {{(XLEN-1){1'b0}}, src_a < src_b};
            4'd5:    alu_result = src_a ^ src_b;
            4'd6:    alu_result = src_a >> shamt;
            4'd7:    alu_result = $signed(src_a) >>> shamt;
            4'd8:    alu_result = src_a | src_b;
            4'd9:    alu_result = src_a & src_b;
            4'd10:   alu_result = src_b;
            default: alu_result = '0;
        endcase
    end

    // Branch compare looks at the forwarded registers, never at the ALU operands.
    always_comb begin
        taken = 1'b0;
        case (bus.funct3E)
            3'b000:  taken = (fwd_a == fwd_b);
            3'b001:  taken = (fwd_a != fwd_b);
            3'b100:  taken = ($signed(fwd_a) <  $signed(fwd_b));
            3'b101:  taken = ($signed(fwd_a) >= $signed(fwd_b));
            3'b110:  taken = (fwd_a <  fwd_b);
            3'b111:  taken = (fwd_a >= fwd_b);
            default: taken = 1'b0;
        endcase
    end

    assign pc_plus4      = bus.PCE + XLEN'(4);
    assign bus.PCTargetE = bus.MuxjalrE ? ((fwd_a + bus.ImmExtE) & ~XLEN'(1))
                                        : (bus.PCE + bus.ImmExtE);
    // A held instruction must not redirect fetch a second time.
    assign bus.PCSrcE    = ~bus.StallM & (bus.JumpE | (bus.BranchE & taken));

    always_comb begin
        m_d = m_q;
        if (bus.FlushM || !bus.StallM) begin
            m_d.alu_result = alu_result;
            m_d.write_data = fwd_b;
            m_d.pc_plus4   = pc_plus4;
            m_d.imm_ext    = bus.ImmExtE;
            m_d.rd         = bus.RdE;
            m_d.funct3     = bus.funct3E;
            m_d.write_back = bus.WriteBackE;
            m_d.reg_write  = bus.RegWriteE;
            m_d.mem_read   = bus.MemReadE;
            m_d.mem_write  = bus.MemWriteE;
        end
        if (bus.FlushM) begin
            m_d.write_back = '0;
            m_d.reg_write  = 1'b0;
            m_d.mem_read   = 1'b0;
            m_d.mem_write  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) m_q <= '0;
        else        m_q <= m_d;
    end

    assign bus.ALUResultM = m_q.alu_result;
    assign bus.WriteDataM = m_q.write_data;
    assign bus.PCPlus4M   = m_q.pc_plus4;
    assign bus.ImmExtM    = m_q.imm_ext;
    assign bus.RdM        = m_q.rd;
    assign bus.funct3M    = m_q.funct3;
    assign bus.WriteBackM = m_q.write_back;
    assign bus.RegWriteM  = m_q.reg_write;
    assign bus.MemReadM   = m_q.mem_read;
    assign bus.MemWriteM  = m_q.mem_write;

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage with hand-computed expected values.
// Inputs change 1 ns after a rising edge; registered outputs are read 1 ns after the edge.
module tb_ex_stage;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    ex_stage_if bus();

    ex_stage u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.StallM = 0; bus.FlushM = 0;
        bus.RD1E = 0; bus.RD2E = 0; bus.PCE = 0; bus.ImmExtE = 0;
        bus.ALUOpE = 0; bus.ALUSrcAE = 0; bus.ALUSrcBE = 0; bus.funct3E = 3'b010;
        bus.BranchE = 0; bus.JumpE = 0; bus.MuxjalrE = 0;
        bus.RegWriteE = 0; bus.MemReadE = 0; bus.MemWriteE = 0;
        bus.WriteBackE = 0; bus.RdE = 0; bus.ForwardAE = 0; bus.ForwardBE = 0;
        bus.ResultW = 0;
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        clear_inputs();
        bus.ALUOpE = op; bus.RD1E = a; bus.RD2E = b;
        step();
        check(tag, bus.ALUResultM, exp);
    endtask

    initial begin
        clear_inputs();

        // Reset state
        #2;
        check("rst_alu", bus.ALUResultM, 32'h0);
        check("rst_regwrite", {31'b0, bus.RegWriteM}, 32'h0);
        check("rst_pcplus4", bus.PCPlus4M, 32'h0);
        step();
        reset = 1'b1;

        // First instruction after reset release
        bus.RD1E = 5; bus.RD2E = 7; bus.ALUOpE = 0; bus.RegWriteE = 1; bus.RdE = 5'd3;
        bus.PCE = 32'h40; bus.funct3E = 3'b010; bus.ImmExtE = 32'h55;
        step();
        check("add_result", bus.ALUResultM, 32'd12);
        check("add_regwrite", {31'b0, bus.RegWriteM}, 32'h1);
        check("add_rd", {27'b0, bus.RdM}, 32'd3);
        check("add_pcplus4", bus.PCPlus4M, 32'h44);
        check("add_imm", bus.ImmExtM, 32'h55);

        // Asynchronous reset mid-cycle with M loaded
        #2 reset = 1'b0;
        #1;
        check("async_rst_alu", bus.ALUResultM, 32'h0);
        check("async_rst_regwrite", {31'b0, bus.RegWriteM}, 32'h0);
        check("async_rst_pcplus4", bus.PCPlus4M, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // ALU sweep
        alu_op(4'd1, 32'd3, 32'd5, 32'hFFFF_FFFE, "sub");
        alu_op(4'd7, 32'h8000_0000, 32'd4, 32'hF800_0000, "sra");
        alu_op(4'd6, 32'h8000_0000, 32'd4, 32'h0800_0000, "srl");
        alu_op(4'd3, 32'hFFFF_FFFF, 32'd1, 32'h1, "slt");
        alu_op(4'd4, 32'hFFFF_FFFF, 32'd1, 32'h0, "sltu");
        alu_op(4'd12, 32'd5, 32'd7, 32'h0, "op12_zero");
        alu_op(4'd2, 32'h1, 32'h23, 32'h8, "sll_shamt5");
        alu_op(4'd5, 32'hF0F0_1234, 32'h0FF0_1200, 32'hFF00_0034, "xor");
        alu_op(4'd8, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, "or");
        alu_op(4'd9, 32'hF0F0_FFFF, 32'h0FF0_00F0, 32'h00F0_00F0, "and");
        alu_op(4'd0, 32'hFFFF_FFFF, 32'd2, 32'h1, "add_wrap");

        // LUI pass-through of the immediate
        clear_inputs();
        bus.ALUOpE = 4'd10; bus.ALUSrcBE = 2'd1; bus.ImmExtE = 32'h1234_5000; bus.RD1E = 32'hDEAD;
        step();
        check("lui", bus.ALUResultM, 32'h1234_5000);

        // Forwarding from M
        alu_op(4'd0, 32'd60, 32'd40, 32'd100, "fwd_setup");
        clear_inputs();
        bus.ForwardAE = 2'b10; bus.RD1E = 1; bus.ImmExtE = 4; bus.ALUSrcBE = 2'd1;
        step();
        check("fwd_a_m", bus.ALUResultM, 32'd104);

        // Forwarding from W into store data
        clear_inputs();
        bus.ForwardBE = 2'b01; bus.ResultW = 32'hAB; bus.RD2E = 32'h11; bus.MemWriteE = 1;
        step();
        check("fwd_b_w_data", bus.WriteDataM, 32'hAB);
        check("fwd_b_memwrite", {31'b0, bus.MemWriteM}, 32'h1);

        // Branches (combinational redirect)
        clear_inputs();
        bus.BranchE = 1; bus.funct3E = 3'b100; bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 0;
        bus.PCE = 32'h100; bus.ImmExtE = 32'h20;
        #1;
        check("blt_pcsrc", {31'b0, bus.PCSrcE}, 32'h1);
        check("blt_target", bus.PCTargetE, 32'h120);
        bus.funct3E = 3'b110;
        #1;
        check("bltu_pcsrc", {31'b0, bus.PCSrcE}, 32'h0);
        bus.funct3E = 3'b010; bus.RD2E = 32'hFFFF_FFFF;
        #1;
        check("f3_010_never", {31'b0, bus.PCSrcE}, 32'h0);
        bus.funct3E = 3'b000;
        #1;
        check("beq_taken", {31'b0, bus.PCSrcE}, 32'h1);

        // JALR: target from forwarded rs1, link via PC+4
        clear_inputs();
        bus.JumpE = 1; bus.MuxjalrE = 1; bus.RD1E = 32'h203; bus.ImmExtE = 0; bus.PCE = 32'h400;
        bus.ALUSrcAE = 2'd1; bus.ALUSrcBE = 2'd2; bus.RegWriteE = 1;
        #1;
        check("jalr_target", bus.PCTargetE, 32'h202);
        check("jalr_pcsrc", {31'b0, bus.PCSrcE}, 32'h1);
        step();
        check("jalr_pcplus4", bus.PCPlus4M, 32'h404);
        check("jalr_link", bus.ALUResultM, 32'h404);

        // PC+4 wrap
        clear_inputs();
        bus.PCE = 32'hFFFF_FFFC;
        step();
        check("pcplus4_wrap", bus.PCPlus4M, 32'h0);

        // Stall for 3 cycles with a taken branch/jump presented
        alu_op(4'd0, 32'd1, 32'd2, 32'd3, "stall_setup");
        bus.RegWriteE = 1; bus.RdE = 5'd7;
        step();
        check("stall_setup_rd", {27'b0, bus.RdM}, 32'd7);
        clear_inputs();
        bus.StallM = 1; bus.BranchE = 1; bus.funct3E = 3'b000; bus.ForwardAE = 2'b10;
        bus.RD2E = 32'd3; bus.JumpE = 1; bus.MuxjalrE = 1; bus.ImmExtE = 32'h10;
        bus.RegWriteE = 1; bus.MemReadE = 1; bus.WriteBackE = 3'd2; bus.RdE = 5'd9;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("stall_pcsrc_%0d", i), {31'b0, bus.PCSrcE}, 32'h0);
            check($sformatf("stall_fwd_target_%0d", i), bus.PCTargetE, 32'h12);
            step();
            check($sformatf("stall_alu_%0d", i), bus.ALUResultM, 32'd3);
            check($sformatf("stall_rd_%0d", i), {27'b0, bus.RdM}, 32'd7);
            check($sformatf("stall_memread_%0d", i), {31'b0, bus.MemReadM}, 32'h0);
        end

        // Release stall: redirect re-enabled, instruction loads
        bus.StallM = 0;
        #1;
        check("unstall_pcsrc", {31'b0, bus.PCSrcE}, 32'h1);
        step();
        check("unstall_alu", bus.ALUResultM, 32'd6);
        check("unstall_memread", {31'b0, bus.MemReadM}, 32'h1);
        check("unstall_wb", {29'b0, bus.WriteBackM}, 32'd2);

        // Flush together with stall clears the control bits
        bus.StallM = 1; bus.FlushM = 1; bus.MemWriteE = 1;
        step();
        check("flush_regwrite", {31'b0, bus.RegWriteM}, 32'h0);
        check("flush_memwrite", {31'b0, bus.MemWriteM}, 32'h0);
        check("flush_memread", {31'b0, bus.MemReadM}, 32'h0);
        check("flush_wb", {29'b0, bus.WriteBackM}, 32'h0);

        clear_inputs();
        step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the RV32I 5-stage pipeline. Consumes the ID/EX register outputs (E-suffixed signals) and applies operand forwarding, the ALU, branch compare and jump-target generation.
- Registers its results into the EX/MEM boundary (M-suffixed outputs) with stall and flush control.
- Produces the PC redirect (PCSrcE/PCTargetE) for the fetch stage and the forwarding source ALUResultM.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all registers update on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- StallM  in  1  hold all M registers.
- FlushM  in  1  synchronous bubble into M.
- RD1E, RD2E  in  32  register-file operands.
- PCE  in  32  PC of the instruction.
- ImmExtE  in  32  sign-extended immediate.
- ALUOpE  in  4  ALU operation select.
- ALUSrcAE  in  2  A-operand select.
- ALUSrcBE  in  2  B-operand select.
- funct3E  in  3  branch/memory subtype.
- BranchE, JumpE, MuxjalrE, RegWriteE, MemReadE, MemWriteE  in  1 each  control bits from ID/EX.
- WriteBackE  in  3  writeback-source select, passed through.
- RdE  in  5  destination register.
- ForwardAE, ForwardBE  in  2  forwarding select from the hazard unit.
- ResultW  in  32  writeback-stage result.
- PCSrcE  out  1  redirect fetch.
- PCTargetE  out  32  redirect address.
- ALUResultM  out  32  registered ALU result.
- WriteDataM  out  32  registered store data.
- PCPlus4M  out  32  registered PCE+4.
- ImmExtM  out  32  registered immediate.
- RdM  out  5  registered destination register.
- funct3M  out  3  registered funct3.
- WriteBackM  out  3  registered writeback select.
- RegWriteM, MemReadM, MemWriteM  out  1 each  registered control bits.

Behaviour:
- Forwarding muxes (combinational):
  - FwdA selects by ForwardAE: 00→RD1E, 01→ResultW, 10→ALUResultM, 11→RD1E.
  - FwdB uses ForwardBE with the same encoding.
- SrcA by ALUSrcAE: 0→FwdA, 1→PCE, 2/3→0.
- SrcB by ALUSrcBE: 0→FwdB, 1→ImmExtE, 2/3→32'd4.
- ALU by ALUOpE:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR.
  - 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass SrcB (LUI).
  - 11-15 produce 0.
  - Shift amount is SrcB[4:0]. Add/sub wrap modulo 2^32. SLT/SLTU produce 0 or 1.
- Branch compare always uses FwdA against FwdB, independent of the ALU:
  - funct3E 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
  - funct3E 010/011 never taken.
- Redirect target:
  - PCTargetE = MuxjalrE ? ((FwdA + ImmExtE) & ~32'd1) : (PCE + ImmExtE).
  - No misalignment trap.
- Redirect enable:
  - PCSrcE = ~StallM & (JumpE | (BranchE & taken)).
  - PCSrcE is combinational, valid in the same cycle as the E inputs.
  - Forced 0 while StallM=1 so a held instruction cannot redirect twice.
- M register, one-cycle latency; priority at each rising clk edge is FlushM > StallM > load.
  - Load: ALUResultM←ALU, WriteDataM←FwdB, PCPlus4M←PCE+4, and all remaining E fields are copied to their M counterparts.
  - StallM=1, FlushM=0: every M output holds its value; no fields are cleared.
  - FlushM=1 (stalled or not): RegWriteM, MemReadM, MemWriteM←0 and WriteBackM←0. Data fields may take the load value but must not be relied on.
- Reset (reset=0, asynchronous): every M output is 0 immediately, independent of clk. Reset de-assertion takes effect on the next edge. Reset mid-stall discards the held instruction.
- Corner cases:
  - RdE=0 passes through unchanged; x0 suppression belongs to the register file.
  - Simultaneous ForwardAE=10 and StallM=1 forwards the held ALUResultM.
  - PCPlus4M wraps at 2^32 (PCE=FFFF_FFFC gives 0).

Test Plan:
- Reset: drive reset=0 mid-cycle with M loaded → all M outputs 0 before the next edge; after release, ADD RD1E=5, RD2E=7 → ALUResultM=12 one edge later, RegWriteM=1.
- ALU sweep:
  - SUB 3-5 → FFFF_FFFE.
  - SRA 8000_0000 by 4 → F800_0000; SRL of the same → 0800_0000.
  - SLT FFFF_FFFF<1 → 1; SLTU of the same → 0.
  - ALUOpE=12 → 0.
- Forwarding: ForwardAE=10 with ALUResultM=100, RD1E=1, ImmExtE=4, ALUSrcBE=1 → ALUResult 104; ForwardBE=01 with ResultW=0xAB, MemWriteE=1 → WriteDataM=0xAB.
- Branch/jump:
  - BLT FwdA=-1, FwdB=0, PCE=0x100, Imm=0x20 → PCSrcE=1, PCTargetE=0x120.
  - BLTU with the same operands → PCSrcE=0.
  - JALR FwdA=0x203, Imm=0 → PCTargetE=0x202, PCPlus4M=PCE+4.
- Stall/flush:
  - StallM=1 for 3 cycles with a taken branch → M outputs frozen, PCSrcE=0 throughout.
  - FlushM=1 together with StallM=1 → RegWriteM, MemWriteM, MemReadM = 0 next edge.
